// File: rtl/bus_arbiter_if.sv
// Bundles the two requester ports, the shared memory port and the status
// outputs of bus_arbiter.
//   master : arbiter view - takes fetch/data requests, drives the memory port
//   slave  : environment view - drives requests and memory responses
// Signal groups: ibus_* (fetch), dbus_* (data), mem_* (shared port),
// flush_i, bus_err_o, stallreq_o.
interface bus_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic          ibus_req_i;
  logic [AW-1:0] ibus_addr_i;
  logic [DW-1:0] ibus_data_o;
  logic          ibus_ack_o;

  logic          dbus_req_i;
  logic          dbus_we_i;
  logic [SW-1:0] dbus_sel_i;
  logic [AW-1:0] dbus_addr_i;
  logic [DW-1:0] dbus_wdata_i;
  logic [DW-1:0] dbus_rdata_o;
  logic          dbus_ack_o;

  logic          flush_i;

  logic          mem_cyc_o;
  logic          mem_stb_o;
  logic          mem_we_o;
  logic [SW-1:0] mem_sel_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;

  logic          bus_err_o;
  logic          stallreq_o;

  modport master (
    input  ibus_req_i, ibus_addr_i,
    output ibus_data_o, ibus_ack_o,
    input  dbus_req_i, dbus_we_i, dbus_sel_i, dbus_addr_i, dbus_wdata_i,
    output dbus_rdata_o, dbus_ack_o,
    input  flush_i,
    output mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i,
    output bus_err_o, stallreq_o
  );

  modport slave (
    output ibus_req_i, ibus_addr_i,
    input  ibus_data_o, ibus_ack_o,
    output dbus_req_i, dbus_we_i, dbus_sel_i, dbus_addr_i, dbus_wdata_i,
    input  dbus_rdata_o, dbus_ack_o,
    output flush_i,
    input  mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i,
    input  bus_err_o, stallreq_o
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shares one Wishbone-style memory port between instruction fetch and the
// data path. One access at a time: IDLE grants a requester, IBUS/DBUS hold
// cyc/stb until mem_ack_i or timeout, then a one-cycle ack goes back.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   bus   - bus_arbiter_if.master (requesters, memory port, flush, status)
module bus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = 16;
  // Abort on the edge that ends the TIMEOUT-th unacknowledged strobe cycle.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IBUS = 2'd1,
    S_DBUS = 2'd2
  } state_t;

  state_t        state_q;
  logic          cyc_q;
  logic          we_q;
  logic [SW-1:0] sel_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] idata_q;
  logic [DW-1:0] drdata_q;
  logic          ibus_ack_q;
  logic          dbus_ack_q;
  logic          err_q;
  logic          drop_q;
  logic          last_data_q;
  logic [CW-1:0] tcnt_q;

  logic ireq_c;
  logic dreq_c;
  logic grant_d_c;
  logic grant_i_c;
  logic done_c;
  logic drop_c;

  // Grant and completion decode. A request being acked this cycle is
  // already served, so it must not win the next grant.
  always_comb begin
    ireq_c    = bus.ibus_req_i & ~ibus_ack_q;
    dreq_c    = bus.dbus_req_i & ~dbus_ack_q;
    grant_d_c = dreq_c & ~(ireq_c & last_data_q);
    grant_i_c = ireq_c & ~grant_d_c;
    done_c    = bus.mem_ack_i | (tcnt_q == TO_LAST);
    drop_c    = (state_q == S_IBUS) & (drop_q | bus.flush_i);
  end

  // Grant state machine with registered bus and requester outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      idata_q     <= '0;
      drdata_q    <= '0;
      ibus_ack_q  <= 1'b0;
      dbus_ack_q  <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      last_data_q <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      ibus_ack_q <= 1'b0;
      dbus_ack_q <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          drop_q <= 1'b0;
          tcnt_q <= '0;
          if (grant_d_c) begin
            state_q <= S_DBUS;
            cyc_q   <= 1'b1;
            we_q    <= bus.dbus_we_i;
            sel_q   <= bus.dbus_sel_i;
            addr_q  <= bus.dbus_addr_i;
            wdata_q <= bus.dbus_wdata_i;
          end else if (grant_i_c) begin
            state_q <= S_IBUS;
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= '1;
            addr_q  <= bus.ibus_addr_i;
          end
        end
        S_IBUS, S_DBUS: begin
          if (done_c) begin
            // Normal ack wins over a coincident timeout; abort returns zero data.
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            drop_q      <= 1'b0;
            last_data_q <= (state_q == S_DBUS);
            err_q       <= ~bus.mem_ack_i;
            if (state_q == S_DBUS) begin
              dbus_ack_q <= 1'b1;
              drdata_q   <= bus.mem_ack_i ? bus.mem_rdata_i : '0;
            end else if (!drop_c) begin
              ibus_ack_q <= 1'b1;
              idata_q    <= bus.mem_ack_i ? bus.mem_rdata_i : '0;
            end
          end else begin
            tcnt_q <= tcnt_q + CW'(1);
            if (drop_c) drop_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_cyc_o    = cyc_q;
  assign bus.mem_stb_o    = cyc_q;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_sel_o    = sel_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.ibus_data_o  = idata_q;
  assign bus.ibus_ack_o   = ibus_ack_q;
  assign bus.dbus_rdata_o = drdata_q;
  assign bus.dbus_ack_o   = dbus_ack_q;
  assign bus.bus_err_o    = err_q;

  // Stall toward ctrl while any request is still outstanding.
  assign bus.stallreq_o = (bus.ibus_req_i & ~ibus_ack_q) |
                          (bus.dbus_req_i & ~dbus_ack_q);
endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int unsigned TO = 8;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  exp_t ib_q[$];
  exp_t db_q[$];

  // memory responder controls and observations
  int          wait_mode = 0;
  bit          hang      = 1'b0;
  bit          spurious  = 1'b0;
  logic [31:0] pl_addr   = '0;
  logic [31:0] pl_wdata  = '0;
  logic        pl_we     = 1'b0;
  logic [3:0]  pl_sel    = '0;
  logic [31:0] grant_log[$];
  logic [31:0] rom [logic [31:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (rom.exists(a)) return rom[a];
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic we, input logic [3:0] sel,
                              input logic [31:0] wd, input bit err);
    exp_t e;
    e.addr  = a;
    e.we    = we;
    e.sel   = sel;
    e.wdata = wd;
    e.err   = err;
    e.data  = err ? 32'h0 : rd_val(a);
    return e;
  endfunction

  // Memory model: ROM-style read data, configurable wait states.
  initial begin : responder
    bit prev_stb;
    int wcnt;
    prev_stb = 1'b0;
    wcnt     = 0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_stb_o && !prev_stb) begin
        pl_addr  = bus.mem_addr_o;
        pl_we    = bus.mem_we_o;
        pl_sel   = bus.mem_sel_o;
        pl_wdata = bus.mem_wdata_o;
        grant_log.push_back(bus.mem_addr_o);
        wcnt = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
      end
      prev_stb = bus.mem_stb_o;
      if (spurious) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hFFFF_FFFF;
      end else if (bus.mem_stb_o && !hang) begin
        if (wcnt == 0) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = rd_val(bus.mem_addr_o);
        end else begin
          bus.mem_ack_i = 1'b0;
          wcnt--;
        end
      end else begin
        bus.mem_ack_i = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every requester ack pops its expected transaction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.ibus_ack_o) begin
        if (ib_q.size() == 0) chk("ibus_ack_unexpected", 32'(bus.ibus_ack_o), 32'h0);
        else begin
          e = ib_q.pop_front();
          chk("ibus_data", bus.ibus_data_o, e.data);
          chk("ibus_err", 32'(bus.bus_err_o), 32'(e.err));
          chk("ibus_addr", pl_addr, e.addr);
          chk("ibus_we", 32'(pl_we), 32'h0);
          chk("ibus_sel", 32'(pl_sel), 32'hF);
        end
      end
      if (bus.dbus_ack_o) begin
        if (db_q.size() == 0) chk("dbus_ack_unexpected", 32'(bus.dbus_ack_o), 32'h0);
        else begin
          e = db_q.pop_front();
          chk("dbus_rdata", bus.dbus_rdata_o, e.data);
          chk("dbus_err", 32'(bus.bus_err_o), 32'(e.err));
          chk("dbus_addr", pl_addr, e.addr);
          chk("dbus_we", 32'(pl_we), 32'(e.we));
          chk("dbus_sel", 32'(pl_sel), 32'(e.sel));
          if (e.we) chk("dbus_wdata", pl_wdata, e.wdata);
        end
      end
      if (bus.bus_err_o && !bus.ibus_ack_o && !bus.dbus_ack_o)
        chk("bus_err_orphan", 32'(bus.bus_err_o), 32'h0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ibus_start(input logic [31:0] a, input bit err);
    ib_q.push_back(mk(a, 1'b0, 4'hF, 32'h0, err));
    bus.ibus_addr_i = a;
    bus.ibus_req_i  = 1'b1;
  endtask

  task automatic dbus_start(input logic [31:0] a, input logic we, input logic [3:0] sel,
                            input logic [31:0] wd, input bit err);
    db_q.push_back(mk(a, we, sel, wd, err));
    bus.dbus_addr_i  = a;
    bus.dbus_we_i    = we;
    bus.dbus_sel_i   = sel;
    bus.dbus_wdata_i = wd;
    bus.dbus_req_i   = 1'b1;
  endtask

  // Hold the request until acked; count foreign completions while waiting.
  task automatic ibus_wait(output int foreign);
    bit got;
    got = 1'b0;
    foreign = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (bus.dbus_ack_o) foreign++;
      if (bus.ibus_ack_o) got = 1'b1;
    end
    if (!got) chk("ibus_ack_timeout", 32'(bus.ibus_ack_o), 32'h1);
    @(posedge clk);
    #1;
    bus.ibus_req_i = 1'b0;
  endtask

  task automatic dbus_wait(output int foreign);
    bit got;
    got = 1'b0;
    foreign = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (bus.ibus_ack_o) foreign++;
      if (bus.dbus_ack_o) got = 1'b1;
    end
    if (!got) chk("dbus_ack_timeout", 32'(bus.dbus_ack_o), 32'h1);
    @(posedge clk);
    #1;
    bus.dbus_req_i = 1'b0;
  endtask

  task automatic rand_ibus(input int n);
    int f;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      cyc_wait(int'($urandom_range(0, 3)));
      a = $urandom & 32'hFFFF_FFFC;
      ibus_start(a, 1'b0);
      ibus_wait(f);
      chk("ibus_fairness", 32'(f <= 1), 32'h1);
    end
  endtask

  task automatic rand_dbus(input int n);
    int f;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      cyc_wait(int'($urandom_range(0, 3)));
      a = $urandom & 32'hFFFF_FFFC;
      dbus_start(a, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, 1'b0);
      dbus_wait(f);
      chk("dbus_fairness", 32'(f <= 1), 32'h1);
    end
  endtask

  initial begin : stim
    int f;
    int n;
    logic [31:0] prev_i;
    logic [31:0] prev_d;

    rst = 1'b0;
    bus.ibus_req_i   = 1'b0;
    bus.ibus_addr_i  = '0;
    bus.dbus_req_i   = 1'b0;
    bus.dbus_we_i    = 1'b0;
    bus.dbus_sel_i   = '0;
    bus.dbus_addr_i  = '0;
    bus.dbus_wdata_i = '0;
    bus.flush_i      = 1'b0;
    rom[32'h0000_0040] = 32'h3401_1100;

    // reset state
    @(negedge clk);
    chk("rst_cyc", 32'(bus.mem_cyc_o), 32'h0);
    chk("rst_stb", 32'(bus.mem_stb_o), 32'h0);
    chk("rst_we", 32'(bus.mem_we_o), 32'h0);
    chk("rst_sel", 32'(bus.mem_sel_o), 32'h0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_wdata", bus.mem_wdata_o, 32'h0);
    chk("rst_iack", 32'(bus.ibus_ack_o), 32'h0);
    chk("rst_dack", 32'(bus.dbus_ack_o), 32'h0);
    chk("rst_idata", bus.ibus_data_o, 32'h0);
    chk("rst_drdata", bus.dbus_rdata_o, 32'h0);
    chk("rst_err", 32'(bus.bus_err_o), 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;

    // zero-wait fetch: stb in cycle 1, ack in cycle 2
    cyc_wait(1);
    ibus_start(32'h0000_0040, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t1_stb", 32'(bus.mem_stb_o), 32'(c == 1));
      chk("t1_stall", 32'(bus.stallreq_o), 32'(c < 2));
      chk("t1_iack", 32'(bus.ibus_ack_o), 32'(c == 2));
    end
    chk("t1_idata", bus.ibus_data_o, 32'h3401_1100);
    @(posedge clk);
    #1;
    bus.ibus_req_i = 1'b0;
    cyc_wait(2);

    // simultaneous requests: data first after a fetch, then alternate
    grant_log.delete();
    fork
      begin ibus_start(32'h0000_0200, 1'b0); ibus_wait(f); end
      begin dbus_start(32'h0000_0100, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b0); dbus_wait(f); end
    join
    cyc_wait(2);
    fork
      begin ibus_start(32'h0000_0300, 1'b0); ibus_wait(f); end
      begin dbus_start(32'h0000_0104, 1'b0, 4'hF, 32'h0, 1'b0); dbus_wait(f); end
    join
    chk("t2_order_len", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("t2_first", grant_log[0], 32'h0000_0100);
      chk("t2_second", grant_log[1], 32'h0000_0200);
      chk("t2_third", grant_log[2], 32'h0000_0104);
      chk("t2_fourth", grant_log[3], 32'h0000_0300);
    end
    cyc_wait(2);

    // flush during a 3-wait-state fetch; redirected fetch follows
    wait_mode = 3;
    prev_i = bus.ibus_data_o;
    bus.ibus_addr_i = 32'h0000_0400;
    bus.ibus_req_i  = 1'b1;
    cyc_wait(2);
    bus.flush_i = 1'b1;
    ibus_start(32'h0000_0500, 1'b0);
    cyc_wait(1);
    bus.flush_i = 1'b0;
    for (int c = 3; c < 6; c++) begin
      @(negedge clk);
      chk("t3_no_iack", 32'(bus.ibus_ack_o), 32'h0);
      chk("t3_stb", 32'(bus.mem_stb_o), 32'(c < 5));
    end
    chk("t3_idata_hold", bus.ibus_data_o, prev_i);
    ibus_wait(f);
    wait_mode = 0;
    cyc_wait(2);

    // asynchronous reset during a data wait; pending fetch then granted
    hang = 1'b1;
    bus.dbus_addr_i = 32'h0000_0700;
    bus.dbus_we_i   = 1'b0;
    bus.dbus_sel_i  = 4'hF;
    bus.dbus_req_i  = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    chk("t5_stb_before", 32'(bus.mem_stb_o), 32'h1);
    rst = 1'b0;
    #1;
    chk("t5_cyc", 32'(bus.mem_cyc_o), 32'h0);
    chk("t5_stb", 32'(bus.mem_stb_o), 32'h0);
    chk("t5_drdata", bus.dbus_rdata_o, 32'h0);
    bus.dbus_req_i = 1'b0;
    hang = 1'b0;
    ibus_start(32'h0000_0800, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_regrant_stb", 32'(bus.mem_stb_o), 32'h1);
    chk("t5_regrant_addr", bus.mem_addr_o, 32'h0000_0800);
    ibus_wait(f);
    cyc_wait(2);

    // timeout: unacked data read aborts after TO strobe cycles
    hang = 1'b1;
    n = 0;
    dbus_start(32'h0000_0600, 1'b0, 4'hF, 32'h0, 1'b1);
    fork
      dbus_wait(f);
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (bus.mem_stb_o) n++;
          if (bus.dbus_ack_o) break;
        end
      end
    join
    chk("t4_stb_cycles", 32'(n), 32'(TO));
    hang = 1'b0;
    cyc_wait(2);

    // spurious memory ack while idle
    prev_i = bus.ibus_data_o;
    prev_d = bus.dbus_rdata_o;
    spurious = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_stb", 32'(bus.mem_stb_o), 32'h0);
      chk("t6_iack", 32'(bus.ibus_ack_o), 32'h0);
      chk("t6_dack", 32'(bus.dbus_ack_o), 32'h0);
    end
    @(posedge clk);
    #1;
    spurious = 1'b0;
    @(negedge clk);
    chk("t6_stb_after", 32'(bus.mem_stb_o), 32'h0);
    chk("t6_idata", bus.ibus_data_o, prev_i);
    chk("t6_drdata", bus.dbus_rdata_o, prev_d);
    @(posedge clk);
    #1;
    dbus_start(32'h0000_0900, 1'b0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    chk("t6_idle_stb", 32'(bus.mem_stb_o), 32'h0);
    @(negedge clk);
    chk("t6_grant_stb", 32'(bus.mem_stb_o), 32'h1);
    dbus_wait(f);
    cyc_wait(2);

    // randomized concurrent traffic with random wait states
    wait_mode = -1;
    fork
      rand_ibus(60);
      rand_dbus(60);
    join
    wait_mode = 0;
    cyc_wait(4);
    chk("ib_q_drained", 32'(ib_q.size()), 32'h0);
    chk("db_q_drained", 32'(db_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one Wishbone-style memory port between the instruction-fetch path (next to pc_reg/if_id) and the data path (mem stage).
- Sequences each access through a grant state machine and returns one-cycle acknowledges to each requester.
- Raises a stall request toward ctrl while any requester is waiting.
- Discards in-flight fetches on branch flush and aborts hung accesses with a timeout.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8)
TIMEOUT, 255, cycles without mem_ack_i before abort (1..2^16-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
ibus_req_i  in  1  fetch request, held until ibus_ack_o
ibus_addr_i  in  AW  fetch address
ibus_data_o  out  DW  fetched instruction
ibus_ack_o  out  1  one-cycle fetch completion pulse
dbus_req_i  in  1  data request, held until dbus_ack_o
dbus_we_i  in  1  1 = write
dbus_sel_i  in  DW/8  byte enables
dbus_addr_i  in  AW  data address
dbus_wdata_i  in  DW  write data
dbus_rdata_o  out  DW  read data
dbus_ack_o  out  1  one-cycle data completion pulse
flush_i  in  1  branch/flush: drop result of in-flight fetch
mem_cyc_o  out  1  bus cycle active
mem_stb_o  out  1  strobe
mem_we_o  out  1  write enable
mem_sel_o  out  DW/8  byte enables
mem_addr_o  out  AW  address
mem_wdata_o  out  DW  write data
mem_rdata_i  in  DW  read data
mem_ack_i  in  1  memory acknowledge
bus_err_o  out  1  one-cycle pulse on timeout abort
stallreq_o  out  1  stall request to ctrl

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- Reset (rst=0, async):
  - state=IDLE.
  - All outputs 0: mem_*, acks, rdata/data outputs, bus_err_o.
  - drop flag, last_grant (=instr) and timeout counter cleared.
- Reset mid-transaction: cyc/stb fall immediately; no ack is issued for that access.
- States: IDLE, IBUS, DBUS.
- Transitions out of IDLE (evaluated at the clock edge):
  - dbus_req_i & ibus_req_i: last_grant==data -> IBUS, else DBUS.
  - only dbus_req_i -> DBUS; only ibus_req_i -> IBUS; neither -> stay IDLE.
- Grant entry:
  - Request fields are latched into mem_addr/we/sel/wdata (registered).
  - mem_cyc_o=mem_stb_o=1 from the cycle after the granting edge.
  - Fetches always drive we=0 and sel=all ones.
- Completion in IBUS/DBUS:
  - At the edge where mem_ack_i=1: mem_rdata_i is captured into the granted requester's data output.
  - The granted ack is pulsed for exactly the next cycle; cyc/stb drop.
  - last_grant is updated; state returns to IDLE.
- Latency and throughput:
  - Zero-wait memory: request cycle 0, stb cycles 1..k (ack in cycle k), requester ack in cycle k+1.
  - Minimum ack latency is 2 cycles. Next grant edge is the end of cycle k+1, so stb resumes in cycle k+2.
- Read data outputs hold their value until the next ack to the same requester. Write transactions also update dbus_rdata_o with mem_rdata_i.
- Flush:
  - flush_i=1 in any cycle while state==IBUS, including the mem_ack_i cycle, sets the drop flag.
  - At completion, ibus_ack_o stays 0 and ibus_data_o is not updated. The bus cycle still completes normally. The drop flag clears on return to IDLE.
  - flush_i in IDLE or DBUS has no effect.
- Timeout:
  - The counter resets on grant entry and increments each IBUS/DBUS cycle with mem_ack_i=0.
  - When the count equals TIMEOUT: cyc/stb drop, the granted ack pulses with data output 0, bus_err_o pulses in the same cycle, and state goes to IDLE.
  - A dropped fetch times out with no ack but still pulses bus_err_o.
- mem_ack_i while IDLE is ignored.
- stallreq_o (combinational) = (ibus_req_i & ~ibus_ack_o) | (dbus_req_i & ~dbus_ack_o).
- Starvation bound: with both requesting continuously, grants alternate, so neither waits more than one foreign transaction.

Test Plan:
- Reset release, ibus_req_i addr 0x0000_0040, memory acks first stb cycle with 0x3401_1100 -> stb cycle 1, ibus_ack_o cycle 2, ibus_data_o=0x3401_1100, stallreq_o=1 cycles 0-1 then 0.
- ibus_req_i and dbus_req_i (write 0xDEAD_BEEF, sel 4'b0011, addr 0x100) both rise in cycle 0 -> data served first with mem_we_o=1, sel 0011; fetch granted next; a third simultaneous pair is then granted data-first again.
- Fetch with 3 wait states, flush_i pulsed in the 2nd stb cycle -> bus cycle completes, no ibus_ack_o, ibus_data_o unchanged, next fetch proceeds normally.
- TIMEOUT=8, dbus read never acked -> cyc/stb drop after 8 stb cycles, dbus_ack_o and bus_err_o pulse together, dbus_rdata_o=0.
- rst driven low between clock edges during a DBUS wait -> mem_cyc_o/stb 0 immediately, no ack; after release, a pending ibus_req_i is granted as from reset.
- Spurious mem_ack_i in IDLE -> no ack, no data change, state stays IDLE.
